// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_pkg;

    localparam int DWORD_W    = 64;
    localparam int BYTE_OFS_W = 3;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_e;

    // Load has priority when both request lines are high; the store is dropped.
    function automatic op_e decode_op(input logic load, input logic store);
        if (load || !store) return OP_LOAD;
        return OP_STORE;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous 1R1W doubleword storage with a registered read port.
// clr forces the read register to zero and suppresses the write (used for faulted accesses).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               we,
    input  logic               clr,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DWORD_W-1:0] wdata,
    output logic [DWORD_W-1:0] rdata
);

    logic [DWORD_W-1:0] mem [2**ADDR_W];
    logic [DWORD_W-1:0] rdata_q;

    // NOTE: the storage array has no reset so it maps onto RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (en && we && !clr) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (en) begin
            if (clr) begin
                rdata_q <= '0;
            end else if (!we) begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures an EX/MEM load/store, stalls the pipeline for the access
// and returns registered read data. Define ALIGN_CHECK_EN to flag misaligned accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DWORD_W-1:0] daddrbus,
    input  logic [DWORD_W-1:0] storedata,
    input  logic               Load,
    input  logic               Store,
    output logic [DWORD_W-1:0] databus,
    output logic               data_valid,
    output logic               stall,
    output logic               align_fault
);

    localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [DWORD_W-1:0] wdata_q;
    op_e                op_q;
    logic               valid_q;

    logic               req;
    logic               idle_start;
    logic               access_now;
    logic [ADDR_W-1:0]  live_idx;
    logic [ADDR_W-1:0]  acc_idx;
    logic [DWORD_W-1:0] acc_wdata;
    op_e                acc_op;
    logic               acc_misalign;
    logic               unused_addr_bits;

    assign req              = Load | Store;
    assign live_idx         = daddrbus[ADDR_W+BYTE_OFS_W-1:BYTE_OFS_W];
    assign unused_addr_bits = ^{daddrbus[DWORD_W-1:ADDR_W+BYTE_OFS_W], daddrbus[BYTE_OFS_W-1:0]};
    assign idle_start       = (state_q == IDLE) && req;

    // With zero wait states the access happens on the accepting edge, so it uses the live inputs.
    assign acc_idx   = (state_q == IDLE) ? live_idx : idx_q;
    assign acc_wdata = (state_q == IDLE) ? storedata : wdata_q;
    assign acc_op    = (state_q == IDLE) ? decode_op(Load, Store) : op_q;

    assign access_now = !reset &&
                        ((idle_start && (WAIT_STATES == 0)) ||
                         ((state_q == WAIT) && (cnt_q == CNT_W'(1))));

    assign stall = idle_start || (state_q == WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_q    <= OP_LOAD;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (req) begin
                        idx_q   <= live_idx;
                        wdata_q <= storedata;
                        op_q    <= decode_op(Load, Store);
                        cnt_q   <= WS;
                        if (WAIT_STATES == 0) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALIGN_CHECK_EN
    logic misalign_q;
    logic fault_q;
    logic live_misalign;

    assign live_misalign = (daddrbus[BYTE_OFS_W-1:0] != '0);
    assign acc_misalign  = (state_q == IDLE) ? live_misalign : misalign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            if (idle_start) begin
                misalign_q <= live_misalign;
            end
            fault_q <= access_now && acc_misalign;
        end
    end

    assign align_fault = fault_q;
`else
    assign acc_misalign = 1'b0;
    assign align_fault  = 1'b0;
`endif

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (access_now),
        .we    (acc_op == OP_STORE),
        .clr   (acc_misalign),
        .addr  (acc_idx),
        .wdata (acc_wdata),
        .rdata (databus)
    );

    assign data_valid = valid_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the EX/MEM → MEM/WB interface. It accepts the load/store request the EX/MEM stage drives (daddrbus, store data, Load, Store). It performs the access against internal doubleword storage after a configurable number of wait states and returns read data for the MEM/WB stage to capture. While an access is outstanding it asserts a stall to the pipeline so the EX/MEM contents hold.

Parameters:
ADDR_W, 8, doubleword index width; storage depth = 2**ADDR_W × 64 bits
WAIT_STATES, 1, extra cycles between request acceptance and completion (0..15)

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  synchronous, active-high reset
daddrbus  in  64  byte address from EX/MEM
storedata  in  64  store data from EX/MEM (register-file B operand)
Load  in  1  load request from EX/MEM
Store  in  1  store request from EX/MEM
databus  out  64  read data toward MEM/WB (registered)
data_valid  out  1  high for exactly the completion cycle (registered)
stall  out  1  combinational; freezes upstream pipeline registers while high
align_fault  out  1  misalignment flag (registered); see Optional Feature

Behaviour:
- Reset is synchronous and active-high: clk is the only clock, reset is sampled on its rising edge.
- Reset values: state=IDLE, databus=0, data_valid=0, align_fault=0, wait counter=0, captured request cleared. Storage contents are not cleared.
- Index = daddrbus[ADDR_W+2:3]. Upper bits are ignored (address wraps modulo depth). Bits [2:0] are ignored unless ALIGN_CHECK_EN is defined.
- Request = Load | Store. If both are high, Load wins and the store is dropped.
- FSM states: IDLE, WAIT, DONE.
  - IDLE + request:
    - capture index, storedata and op; cnt <= WAIT_STATES.
    - Next state is WAIT if WAIT_STATES>0, else DONE.
    - If WAIT_STATES==0, the access is performed on this same edge.
  - IDLE, no request: stay in IDLE.
  - WAIT: cnt decrements each edge. On the edge where cnt==1, perform the access and go to DONE.
  - Performing the access:
    - load: databus <= mem[index].
    - store: mem[index] <= captured data; databus holds its previous value.
    - In both cases data_valid <= 1.
  - DONE: unconditionally go to IDLE on the next edge; data_valid <= 0; databus holds.
- stall = (state==IDLE & request) | (state==WAIT). stall is low in DONE, so MEM/WB captures databus and EX/MEM advances on the DONE→IDLE edge.
- Throughput: one access per WAIT_STATES+2 cycles. A back-to-back request is seen in the IDLE cycle following DONE.
- Inputs are sampled only in IDLE. Changes to inputs during WAIT are ignored.
- Reset mid-access (WAIT or DONE): the access is abandoned, a pending store is not written, and outputs return to reset values on that edge.

Optional Feature:
ALIGN_CHECK_EN
- Defined:
  - The captured request also records daddrbus[2:0]!=0.
  - A misaligned access writes nothing and sets databus <= 0.
  - align_fault <= 1 with the same timing as data_valid, cleared together with it.
- Undefined: bits [2:0] are ignored and align_fault is tied to 0.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, DONE}
  - op encoding (OP_LOAD, OP_STORE)
  - DWORD_W=64, BYTE_OFS_W=3
- Sub-module dmem_array: synchronous 1R1W 64-bit storage with en/we, read data registered. The responder owns only the FSM, counter, capture registers and stall logic.

Test Plan:
- reset held 2 cycles, then released with no request → databus=0, data_valid=0, stall=0, state IDLE.
- WAIT_STATES=1:
  - Store daddrbus=0x40, storedata=0xDEADBEEF_CAFEF00D → stall high for 2 cycles, data_valid pulses 1 cycle.
  - Then Load 0x40 → databus=0xDEADBEEF_CAFEF00D in the data_valid cycle.
- WAIT_STATES=0:
  - Back-to-back loads of 0x0 then 0x8 (preloaded 0x11, 0x22) → data_valid 1 cycle in every 2, databus 0x11 then 0x22, stall high exactly in each IDLE-with-request cycle.
- Load=Store=1 at 0x10 (mem=0x5, storedata=0x9) → databus=0x5, mem[2] still 0x5.
- reset asserted in WAIT during a store of 0x77 to 0x18 → mem[3] unchanged, data_valid never pulses, stall=0 after the reset edge.
- Address wrap and alignment:
  - ADDR_W=8: store to 0x800 then load 0x0 → same value.
  - With ALIGN_CHECK_EN: load 0x43 → align_fault=1, databus=0, no write.
